// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mips_mem_pkg
//  Description : Shared constants for the 17-bit core data-memory responder.
//  Revision    : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam int XLEN = 17;

    localparam int c_mmio_bit = 16;

    localparam logic [2:0] c_off_fifo_data = 3'd0;
    localparam logic [2:0] c_off_status    = 3'd1;
    localparam logic [2:0] c_off_cycles    = 3'd2;
    localparam logic [2:0] c_off_ctrl      = 3'd3;

    localparam int c_st_count_w = 5;
    localparam int c_st_empty   = 5;
    localparam int c_st_full    = 6;
    localparam int c_st_ovf     = 7;

    localparam int c_ctrl_clr_ovf = 0;
    localparam int c_ctrl_flush   = 1;

    function automatic logic [XLEN-1:0] pack_status(
        input logic [c_st_count_w-1:0] cnt,
        input logic                    empty,
        input logic                    full,
        input logic                    ovf
    );
        logic [XLEN-1:0] s;
        s                    = '0;
        s[c_st_count_w-1:0]  = cnt;
        s[c_st_empty]        = empty;
        s[c_st_full]         = full;
        s[c_st_ovf]          = ovf;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with push/pop/flush and full/empty/count.
//  Revision    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_drop,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_cnt);
    // A pop frees a slot in the same edge, so a full FIFO still takes the push.
    assign w_pop   = i_pop && !w_empty && !i_flush;
    assign w_push  = i_push && !i_flush && (!w_full || w_pop);
    assign o_drop  = i_push && !i_flush && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Data RAM plus MMIO (output FIFO, status, cycle counter).
//  Revision    : 1.0
// ============================================================================
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int RAM_AW     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] aluout,
    input  logic [XLEN-1:0] writedata,
    input  logic            memwrite,
    output logic [XLEN-1:0] readdata,
    output logic [XLEN-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] r_ram [2**RAM_AW];
    logic [XLEN-1:0] r_cycles;
    logic            r_overflow;

    logic              w_is_mmio;
    logic [2:0]        w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_st_fifo;
    logic              w_st_cycles;
    logic              w_st_ctrl;
    logic              w_flush;
    logic              w_clr_ovf;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [CW-1:0]     w_count;
    logic [XLEN-1:0]   w_status;
    logic              w_unused;

    assign w_is_mmio   = aluout[c_mmio_bit];
    assign w_off       = aluout[2:0];
    assign w_ram_idx   = aluout[RAM_AW-1:0];
    assign w_st_fifo   = memwrite && w_is_mmio && (w_off == c_off_fifo_data);
    assign w_st_cycles = memwrite && w_is_mmio && (w_off == c_off_cycles);
    assign w_st_ctrl   = memwrite && w_is_mmio && (w_off == c_off_ctrl);
    assign w_flush     = w_st_ctrl && writedata[c_ctrl_flush];
    assign w_clr_ovf   = w_st_ctrl && writedata[c_ctrl_clr_ovf];
    assign w_unused    = ^aluout[15:3];

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_st_fifo),
        .i_wdata (writedata),
        .i_pop   (out_ready),
        .i_flush (w_flush),
        .o_rdata (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop),
        .o_count (w_count)
    );

    assign out_valid = !w_empty;

    always_ff @(posedge clk) begin
        if (memwrite && !w_is_mmio) r_ram[w_ram_idx] <= writedata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_st_cycles) begin
            r_cycles <= writedata;
        end else begin
            r_cycles <= r_cycles + 1'b1;
        end
    end

    // Setting outranks clearing when both land on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign w_status = pack_status(c_st_count_w'(w_count), w_empty, w_full, r_overflow);

    always_comb begin
        readdata = '0;
        if (!w_is_mmio) begin
            readdata = r_ram[w_ram_idx];
        end else begin
            case (w_off)
                c_off_status: readdata = w_status;
                c_off_cycles: readdata = r_cycles;
                default:      readdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 17-bit single-cycle core: it receives the core's data-port requests (address, write data, write strobe) and returns read data in the same cycle. It holds a word-addressed data RAM and a small memory-mapped I/O region. The I/O region contains an output FIFO drained by an external consumer over a valid/ready handshake, a status register and a free-running cycle counter. It sits beside the core at top level, wired to the core's aluout/writedata/memwrite/readdata.

## Interface
Parameters:
- RAM_AW, 8: RAM word-address width (2^RAM_AW words of 17 bits).
- FIFO_DEPTH, 8: output FIFO entries; must be a power of two, at most 16.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- aluout  in  17  data address from the core (word address).
- writedata  in  17  store data from the core.
- memwrite  in  1  store strobe; a store commits at the next rising edge.
- readdata  out  17  load data; combinational from aluout and current state.
- out_data  out  17  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head when out_valid and out_ready are both high at a rising edge.

## Operation
- Address decode:
  - aluout[16]=0: RAM, index aluout[RAM_AW-1:0]. Upper bits are ignored, so addresses alias.
  - aluout[16]=1: MMIO, selected by aluout[2:0]. aluout[15:3] are ignored.
- RAM:
  - Store writes writedata at the edge.
  - Load returns the stored word combinationally.
  - Contents are not reset.
- MMIO offsets:
  - 0 FIFO_DATA: store pushes writedata; load returns 0.
  - 1 STATUS: read-only. Bits [4:0] count, bit5 empty, bit6 full, bit7 overflow, [16:8] zero.
  - 2 CYCLES: load returns the counter; store loads it with writedata.
  - 3 CTRL: store bit0=1 clears overflow; bit1=1 flushes the FIFO. Load returns 0.
  - 4..7: load returns 0; stores ignored.
- FIFO rules:
  - A push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - A push to a full FIFO with no simultaneous pop is dropped, and overflow is set sticky.
  - Push and pop in the same cycle leave count unchanged.
  - Flush sets count to 0 and discards any pop that cycle.
  - Overflow clears only through CTRL bit0. If a clear and an overflow event coincide, set wins; this cannot occur from a single store but the rule is fixed anyway.
- Cycle counter:
  - Increments by 1 every cycle and wraps from 0x1FFFF to 0.
  - On a CYCLES store, the next value is writedata, with no increment that cycle.
- out_data:
  - Equals the head entry while out_valid.
  - Equals 0 when empty.

## Timing
- Reset values: readdata follows decode (RAM reads are undefined before first write); out_data 0; out_valid 0; count 0; overflow 0; counter 0. FIFO pointers are zeroed.
- Reset mid-operation empties the FIFO and discards any pending push. RAM is untouched.
- Load latency: 0 cycles. A load in the same cycle as a store to the same address returns the old value.
- Push-to-visibility: out_valid rises 1 cycle after an accepted push into an empty FIFO. STATUS reflects the push in the following cycle.
- Pointers wrap modulo FIFO_DEPTH. Count is clog2(FIFO_DEPTH)+1 bits wide.
- A STATUS read returns pre-edge state. Likewise a CYCLES read returns the value before that edge's increment.

## Structure
- Package mips_mem_pkg:
  - XLEN=17.
  - MMIO select bit (16).
  - Offset constants FIFO_DATA/STATUS/CYCLES/CTRL.
  - Status bit positions.
  - CTRL bit positions.
- Sub-module sync_fifo: parameterised width/depth, push/pop/flush, with full/empty/count outputs.
- dmem_responder contains the decode, RAM array, counter and overflow flag.

## Test plan
- Reset, then store 0x1ABCD to address 0x00005 and load 0x00005 → readdata 0x1ABCD. Load 0x00105 (alias) → 0x1ABCD.
- out_ready=0; store 0x11,0x22,…,0x88 to 0x10000 (8 pushes), then a 9th store of 0x99 → STATUS = 0x0C8 (count 8, full, overflow). Raise out_ready → out_data sequence 0x11..0x88, then out_valid=0 and STATUS=0x0A0 (empty, overflow). Store 1 to CTRL → STATUS=0x020.
- FIFO full with out_ready=1 and a simultaneous push of 0x55 → push accepted, count stays 8, overflow stays 0, 0x55 emerges last.
- Store 0x1FFFE to CYCLES, then read on the next 3 cycles → 0x1FFFE, 0x1FFFF, 0x00000.
- Push 3 words, then store 2 to CTRL while out_ready=1 → next cycle count 0, out_valid 0, out_data 0.
- Assert reset for one cycle with 4 entries queued and the counter at 0x00100 → out_valid 0, STATUS 0x020, CYCLES 0; a previously written RAM word reads back unchanged.
